// File: rtl/floppy_voice_sched.sv
// Note-event scheduler: maps note-on/off events onto NUM_VOICES floppy tone channels.
// Optional feature macro VOICE_STEAL_EN: a note-on with all voices busy steals the oldest voice.
module floppy_voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int SP_W       = 22,
  parameter int DROP_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [6:0]                 ev_note,
  input  logic [SP_W-1:0]            ev_period,
  output logic [NUM_VOICES-1:0]      voice_en,
  output logic [NUM_VOICES*SP_W-1:0] voice_sp,
  output logic [DROP_W-1:0]          drop_cnt
);
  localparam int AGE_W = $clog2(NUM_VOICES) + 1;

  // Handshake: an event transfers on any posedge where ev_valid && ev_ready;
  // ev_ready depends only on state, never on ev_valid.
  typedef enum logic {IDLE = 1'b0, DECIDE = 1'b1} state_t;
  state_t state, state_nxt;

  logic                  lat_on;
  logic [6:0]            lat_note;
  logic [SP_W-1:0]       lat_period;

  logic [NUM_VOICES-1:0] en_q, en_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [SP_W-1:0]       sp_q   [NUM_VOICES];
  logic [SP_W-1:0]       sp_d   [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];
  logic [AGE_W-1:0]      age_d  [NUM_VOICES];
  logic [DROP_W-1:0]     drop_q, drop_d;

  logic hit, free_any, place;
  int   hit_idx, free_idx, tgt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev_valid) state_nxt = DECIDE;
      DECIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ev_ready = (state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_on     <= 1'b0;
      lat_note   <= '0;
      lat_period <= '0;
    end else if (ev_valid && ev_ready) begin
      lat_on     <= ev_on;
      lat_note   <= ev_note;
      lat_period <= ev_period;
    end
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 0;
    free_any = 1'b0;
    free_idx = 0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (en_q[i] && note_q[i] == lat_note) begin
        hit     = 1'b1;
        hit_idx = i;
      end
      if (!en_q[i]) begin
        free_any = 1'b1;
        free_idx = i;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0] old_age;
  int               old_idx;

  // Strict greater-than keeps the lowest index on an age tie.
  always_comb begin
    old_idx = 0;
    old_age = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = i;
      end
    end
  end
`endif

  always_comb begin
    en_d   = en_q;
    note_d = note_q;
    sp_d   = sp_q;
    age_d  = age_q;
    drop_d = drop_q;
    place  = 1'b0;
    tgt    = 0;
    if (state == DECIDE) begin
      if (lat_on) begin
        if (lat_period != '0) begin
          if (hit) begin
            place = 1'b1;
            tgt   = hit_idx;
          end else if (free_any) begin
            place = 1'b1;
            tgt   = free_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            place = 1'b1;
            tgt   = old_idx;
`else
            drop_d = drop_q + 1'b1;
`endif
          end
        end
      end else if (hit) begin
        en_d[hit_idx] = 1'b0;
      end
      if (place) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (i == tgt) begin
            en_d[i]   = 1'b1;
            note_d[i] = lat_note;
            sp_d[i]   = lat_period;
            age_d[i]  = '0;
          end else if (en_q[i] && age_q[i] != '1) begin
            age_d[i] = age_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= '0;
      drop_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        sp_q[i]   <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      en_q   <= en_d;
      note_q <= note_d;
      sp_q   <= sp_d;
      age_q  <= age_d;
      drop_q <= drop_d;
    end
  end

  always_comb begin
    voice_sp = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_sp[i*SP_W +: SP_W] = sp_q[i];
  end

  assign voice_en = en_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_floppy_voice_sched.sv
// Bench for floppy_voice_sched: directed scenarios plus random events checked
// against an array-based voice model; define VOICE_STEAL_EN to match a steal build.
module tb_floppy_voice_sched;
  localparam int NV     = 4;
  localparam int SP_W   = 22;
  localparam int DROP_W = 8;
  localparam int AGE_MAX = (1 << ($clog2(NV) + 1)) - 1;
  localparam int W = DROP_W + NV + NV * SP_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  ev_valid = 1'b0;
  logic                  ev_ready;
  logic                  ev_on = 1'b0;
  logic [6:0]            ev_note = '0;
  logic [SP_W-1:0]       ev_period = '0;
  logic [NV-1:0]         voice_en;
  logic [NV*SP_W-1:0]    voice_sp;
  logic [DROP_W-1:0]     drop_cnt;

  floppy_voice_sched #(.NUM_VOICES(NV), .SP_W(SP_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_period(ev_period),
    .voice_en(voice_en), .voice_sp(voice_sp), .drop_cnt(drop_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_en[NV], m_note[NV], m_sp[NV], m_age[NV];
  int m_drop;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_en[i] = 0; m_note[i] = 0; m_sp[i] = 0; m_age[i] = 0;
    end
    m_drop = 0;
  endfunction

  function automatic void model_event(input bit on, input int note, input int period);
    int tgt = -1;
    if (on) begin
      if (period == 0) return;
      for (int i = 0; i < NV; i++) if (tgt < 0 && m_en[i] != 0 && m_note[i] == note) tgt = i;
      for (int i = 0; i < NV; i++) if (tgt < 0 && m_en[i] == 0) tgt = i;
      if (tgt < 0) begin
`ifdef VOICE_STEAL_EN
        tgt = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
`else
        m_drop = (m_drop + 1) % (1 << DROP_W);
        return;
`endif
      end
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_en[i] != 0 && m_age[i] < AGE_MAX) m_age[i]++;
      m_en[tgt] = 1; m_note[tgt] = note; m_sp[tgt] = period; m_age[tgt] = 0;
    end else begin
      for (int i = 0; i < NV; i++) if (m_en[i] != 0 && m_note[i] == note) m_en[i] = 0;
    end
  endfunction

  function automatic logic [W-1:0] model_pack();
    logic [NV*SP_W-1:0] sp;
    logic [NV-1:0]      en;
    logic [DROP_W-1:0]  d;
    for (int i = 0; i < NV; i++) begin
      sp[i*SP_W +: SP_W] = SP_W'(m_sp[i]);
      en[i] = (m_en[i] != 0);
    end
    d = DROP_W'(m_drop);
    return {d, en, sp};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a completed decision shows as ev_ready returning high.
  int low_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      low_cnt = 0;
    end else if (!ev_ready) begin
      low_cnt++;
    end else begin
      if (low_cnt > 0) begin
        chk("ready_low_cycles", W'(low_cnt), W'(1));
        if (exp_q.size() == 0) begin
          chk("unexpected_output", W'(1), W'(0));
        end else begin
          chk("outputs", {drop_cnt, voice_en, voice_sp}, exp_q.pop_front());
        end
      end
      low_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  time acc_t;

  task automatic idle(input int n);
    ev_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    idle(3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with ev_valid still high.
  task automatic send(input bit on, input int note, input int period);
    int budget = 0;
    ev_valid  = 1'b1;
    ev_on     = on;
    ev_note   = 7'(note);
    ev_period = SP_W'(period);
    while (!ev_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) begin
      chk("accept_timeout", W'(0), W'(1));
    end else begin
      model_event(on, note, period);
      exp_q.push_back(model_pack());
      @(posedge clk);
      acc_t = $time;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  time t_prev;
  int  gap;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ready", W'(ev_ready), W'(1));
    chk("reset_outputs", {drop_cnt, voice_en, voice_sp}, W'(0));
    @(negedge clk);

    // single note-on
    send(1, 60, 1000); idle(3);

    // free-voice reuse after note-off
    do_reset();
    send(1, 60, 1100); idle(1);
    send(1, 62, 1200); idle(1);
    send(1, 64, 1300); idle(1);
    send(0, 62, 0);    idle(1);
    send(1, 67, 1700); idle(2);

    // retrigger and unmatched note-off
    do_reset();
    send(1, 60, 1000); idle(1);
    send(1, 60, 500);  idle(1);
    send(0, 61, 0);    idle(2);

    // all voices busy: steal or drop
    do_reset();
    send(1, 60, 100); idle(1);
    send(1, 62, 200); idle(1);
    send(1, 64, 300); idle(1);
    send(1, 65, 400); idle(1);
    send(1, 67, 500); idle(1);
    send(1, 69, 600); idle(2);

    // back-to-back events, then a zero-period note-on
    do_reset();
    send(1, 50, 10); t_prev = acc_t;
    for (int k = 0; k < 3; k++) begin
      send(1, 51 + k, 20 + k);
      gap = int'((acc_t - t_prev) / 10);
      chk("accept_spacing", W'(gap), W'(2));
      t_prev = acc_t;
    end
    send(1, 70, 0); idle(3);

    // reset during DECIDE aborts the event
    send(1, 72, 777); idle(3);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd73; ev_period = SP_W'(888);
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", W'(ev_ready), W'(1));
    chk("abort_outputs", {drop_cnt, voice_en, voice_sp}, W'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // random traffic over a narrow note range to force hits and full voices
    for (int k = 0; k < 400; k++) begin
      bit on;
      int note, period;
      on     = ($urandom_range(0, 99) < 65);
      note   = 60 + $urandom_range(0, 7);
      period = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, (1 << SP_W) - 1);
      send(on, note, period);
      idle($urandom_range(0, 2));
    end
    idle(4);

    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
